// File: rtl/branch_pkg.sv
// Shared definitions for the flow-control path: opcodes, sequencer states,
// flag-select indices and small opcode-decoding helpers.
package branch_pkg;

    // Flow-control opcodes
    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JC   = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_CC   = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_CR   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Flag indices, shared with the flag register and the decoder
    localparam logic [2:0] FL_Z  = 3'd0;
    localparam logic [2:0] FL_NZ = 3'd1;
    localparam logic [2:0] FL_C  = 3'd2;
    localparam logic [2:0] FL_NC = 3'd3;
    localparam logic [2:0] FL_P  = 3'd4;
    localparam logic [2:0] FL_N  = 3'd5;
    localparam logic [2:0] FL_PO = 3'd6;
    localparam logic [2:0] FL_PE = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EVAL   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    // What a taken control op does to the PC / return stack
    typedef enum logic [1:0] {
        CLS_JUMP = 2'd0,
        CLS_CALL = 2'd1,
        CLS_RET  = 2'd2
    } ctl_class_e;

    // Conditional ops take their outcome from the sampled flag
    function automatic logic op_is_cond(input logic [2:0] op);
        return (op == OP_JC) || (op == OP_CC) || (op == OP_CR);
    endfunction

    function automatic ctl_class_e op_class(input logic [2:0] op);
        ctl_class_e cls;
        case (op)
            OP_CALL, OP_CC: cls = CLS_CALL;
            OP_RET,  OP_CR: cls = CLS_RET;
            default:        cls = CLS_JUMP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Small LIFO of return addresses. The pointer counts 0..DEPTH so full and
// empty are unambiguous; only the pointer is reset, contents are left as-is.
module return_stack
    import branch_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = IW + 1;

    logic [PW-1:0] sp_q, sp_d;
    logic [AW-1:0] mem_q [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [PW-1:0] sp_m1;

    assign full   = (sp_q == PW'(DEPTH));
    assign empty  = (sp_q == '0);
    assign sp_m1  = sp_q - 1'b1;
    // Write slot is the pointer itself; it is never used while full
    assign wr_idx = sp_q[IW-1:0];
    // Top-of-stack sits one below the pointer
    assign rd_idx = sp_m1[IW-1:0];
    assign dout   = mem_q[rd_idx];

    // Pointer next-state: push and pop are refused at the limits
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_d = sp_m1;
        end
    end

    // Pointer register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Flow-control sequencer between decode and fetch. Accepts one decoded
// instruction per cycle, evaluates conditions through the flag register's
// select/return pair, and steers the PC with a hardware return stack.
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [2:0]    instr_cond,
    input  logic [AW-1:0] instr_target,
    output logic [2:0]    oc_fl,
    input  logic          fl,
    output logic [AW-1:0] pc,
    output logic          fetch_en,
    output logic          branch_taken,
    output logic          stack_err
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [2:0]    oc_fl_q, oc_fl_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic          bt_q, bt_d;
    logic          err_q, err_d;

    logic          rs_push, rs_pop;
    logic [AW-1:0] rs_dout;
    logic          rs_full, rs_empty;
    logic [AW-1:0] pc_inc;
    logic          take;

    // pc+1 wraps naturally at AW bits; also the value pushed on a call
    assign pc_inc = pc_q + 1'b1;

    // Unconditional ops always take; conditional ops use the live flag,
    // which the flag register has already updated for this EVAL cycle
    assign take = op_is_cond(op_q) ? fl : 1'b1;

    return_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rs_push),
        .pop   (rs_pop),
        .din   (pc_inc),
        .dout  (rs_dout),
        .full  (rs_full),
        .empty (rs_empty)
    );

    // Handshake and fetch gating depend only on state
    assign instr_ready  = (state_q == ST_RUN);
    assign fetch_en     = (state_q == ST_RUN);
    assign pc           = pc_q;
    assign oc_fl        = oc_fl_q;
    assign branch_taken = bt_q;
    assign stack_err    = err_q;

    // FSM next-state and PC / stack resolution
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        oc_fl_d = oc_fl_q;
        op_d    = op_q;
        tgt_d   = tgt_q;
        bt_d    = 1'b0;
        err_d   = err_q;
        rs_push = 1'b0;
        rs_pop  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (instr_valid) begin
                    case (instr_op)
                        OP_SEQ:  pc_d = pc_inc;
                        OP_HALT: state_d = ST_HALTED;
                        default: begin
                            op_d    = instr_op;
                            tgt_d   = instr_target;
                            oc_fl_d = instr_cond;
                            state_d = ST_EVAL;
                        end
                    endcase
                end
            end

            ST_EVAL: begin
                state_d = ST_RUN;
                if (!take) begin
                    // Untaken conditionals leave stack and error flag alone
                    pc_d = pc_inc;
                end else begin
                    case (op_class(op_q))
                        CLS_CALL: begin
                            if (rs_full) begin
                                pc_d  = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                rs_push = 1'b1;
                                pc_d    = tgt_q;
                                bt_d    = 1'b1;
                            end
                        end
                        CLS_RET: begin
                            if (rs_empty) begin
                                pc_d  = pc_inc;
                                err_d = 1'b1;
                            end else begin
                                rs_pop = 1'b1;
                                pc_d   = rs_dout;
                                bt_d   = 1'b1;
                            end
                        end
                        default: begin
                            pc_d = tgt_q;
                            bt_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_HALTED: state_d = ST_HALTED;

            default: state_d = ST_RUN;
        endcase
    end

    // State, PC and flag registers; reset forces RUN even mid-EVAL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            oc_fl_q <= '0;
            op_q    <= OP_SEQ;
            tgt_q   <= '0;
            bt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oc_fl_q <= oc_fl_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            bt_q    <= bt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: a table of instruction vectors with expected
// pc / branch_taken / stack_err pushed to a scoreboard queue at issue and
// popped when the op resolves, plus hand-written reset/wrap/halt sequences.
module tb_branch_sequencer;
    import branch_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [2:0]    instr_cond;
    logic [AW-1:0] instr_target;
    logic [2:0]    oc_fl;
    logic          fl;
    logic [AW-1:0] pc;
    logic          fetch_en;
    logic          branch_taken;
    logic          stack_err;

    branch_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_cond   (instr_cond),
        .instr_target (instr_target),
        .oc_fl        (oc_fl),
        .fl           (fl),
        .pc           (pc),
        .fetch_en     (fetch_en),
        .branch_taken (branch_taken),
        .stack_err    (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [2:0]    cond;
        logic [AW-1:0] tgt;
        logic          flv;
        logic [AW-1:0] exp_pc;
        logic          exp_bt;
        logic          exp_err;
    } vec_t;

    vec_t tbl [24];
    vec_t sb  [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] cond,
                                input logic [AW-1:0] tgt, input logic flv,
                                input logic [AW-1:0] epc, input logic ebt, input logic eerr);
        vec_t v;
        v.op = op; v.cond = cond; v.tgt = tgt; v.flv = flv;
        v.exp_pc = epc; v.exp_bt = ebt; v.exp_err = eerr;
        return v;
    endfunction

    // Assert reset for one full cycle; returns just after a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one instruction (called just after a falling edge, with the
    // sequencer in RUN) and check its resolution from the scoreboard
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        instr_valid  = 1'b1;
        instr_op     = v.op;
        instr_cond   = v.cond;
        instr_target = v.tgt;
        fl           = v.flv;
        sb.push_back(v);
        @(negedge clk);
        instr_valid = 1'b0;
        if (v.op != OP_SEQ && v.op != OP_HALT) begin
            chk({tag, " oc_fl"}, 32'(oc_fl), 32'(v.cond));
            chk({tag, " ready_eval"}, 32'(instr_ready), 32'd0);
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, " pc"}, 32'(pc), 32'(e.exp_pc));
        chk({tag, " branch_taken"}, 32'(branch_taken), 32'(e.exp_bt));
        chk({tag, " stack_err"}, 32'(stack_err), 32'(e.exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] frozen;
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr_op     = OP_SEQ;
        instr_cond   = 3'd0;
        instr_target = '0;
        fl           = 1'b0;

        tbl[0]  = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
        tbl[1]  = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h02, 1'b0, 1'b0);
        tbl[2]  = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h03, 1'b0, 1'b0);
        tbl[3]  = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h04, 1'b0, 1'b0);
        tbl[4]  = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h05, 1'b0, 1'b0);
        tbl[5]  = mk(OP_JC,   FL_C,  8'h40, 1'b1, 8'h40, 1'b1, 1'b0);
        tbl[6]  = mk(OP_JC,   FL_C,  8'h80, 1'b0, 8'h41, 1'b0, 1'b0);
        tbl[7]  = mk(OP_JMP,  FL_Z,  8'h05, 1'b0, 8'h05, 1'b1, 1'b0);
        tbl[8]  = mk(OP_CALL, FL_Z,  8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
        tbl[9]  = mk(OP_RET,  FL_Z,  8'h00, 1'b0, 8'h06, 1'b1, 1'b0);
        tbl[10] = mk(OP_CR,   FL_NZ, 8'h00, 1'b0, 8'h07, 1'b0, 1'b0);
        tbl[11] = mk(OP_CC,   FL_NC, 8'h30, 1'b0, 8'h08, 1'b0, 1'b0);
        tbl[12] = mk(OP_CC,   FL_NC, 8'h30, 1'b1, 8'h30, 1'b1, 1'b0);
        tbl[13] = mk(OP_CR,   FL_P,  8'h00, 1'b1, 8'h09, 1'b1, 1'b0);
        tbl[14] = mk(OP_CALL, FL_Z,  8'h20, 1'b0, 8'h20, 1'b1, 1'b0);
        tbl[15] = mk(OP_CALL, FL_Z,  8'h21, 1'b0, 8'h21, 1'b1, 1'b0);
        tbl[16] = mk(OP_CALL, FL_Z,  8'h22, 1'b0, 8'h22, 1'b1, 1'b0);
        tbl[17] = mk(OP_CALL, FL_Z,  8'h23, 1'b0, 8'h23, 1'b1, 1'b0);
        tbl[18] = mk(OP_CALL, FL_Z,  8'h99, 1'b0, 8'h24, 1'b0, 1'b1);
        tbl[19] = mk(OP_RET,  FL_Z,  8'h00, 1'b0, 8'h23, 1'b1, 1'b1);
        tbl[20] = mk(OP_RET,  FL_Z,  8'h00, 1'b0, 8'h22, 1'b1, 1'b1);
        tbl[21] = mk(OP_RET,  FL_Z,  8'h00, 1'b0, 8'h21, 1'b1, 1'b1);
        tbl[22] = mk(OP_RET,  FL_Z,  8'h00, 1'b0, 8'h0A, 1'b1, 1'b1);
        tbl[23] = mk(OP_SEQ,  FL_Z,  8'h00, 1'b0, 8'h0B, 1'b0, 1'b1);

        // Reset state
        do_reset();
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst oc_fl", 32'(oc_fl), 32'd0);
        chk("rst ready", 32'(instr_ready), 32'd1);
        chk("rst fetch_en", 32'(fetch_en), 32'd1);
        chk("rst branch_taken", 32'(branch_taken), 32'd0);
        chk("rst stack_err", 32'(stack_err), 32'd0);

        // Vector table
        for (int i = 0; i < 24; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Underflow with pc wrap from 0xFF
        do_reset();
        apply(mk(OP_JMP, FL_Z, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0), "wrap jmp");
        apply(mk(OP_RET, FL_Z, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1), "wrap ret");

        // Reset mid-EVAL of a CALL after one completed push
        apply(mk(OP_SEQ,  FL_Z, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1), "mid seq");
        apply(mk(OP_CALL, FL_Z, 8'h10, 1'b0, 8'h10, 1'b1, 1'b1), "mid call");
        instr_valid  = 1'b1;
        instr_op     = OP_CALL;
        instr_cond   = FL_N;
        instr_target = 8'h20;
        @(negedge clk);
        chk("mid eval oc_fl", 32'(oc_fl), 32'(FL_N));
        rst_n = 1'b0;
        instr_valid = 1'b0;
        #1;
        chk("mid rst pc", 32'(pc), 32'd0);
        chk("mid rst ready", 32'(instr_ready), 32'd1);
        chk("mid rst oc_fl", 32'(oc_fl), 32'd0);
        chk("mid rst stack_err", 32'(stack_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(OP_RET, FL_Z, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1), "post rst ret");

        // HALT freezes everything until reset
        apply(mk(OP_HALT, FL_Z, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1), "halt");
        frozen = 8'h01;
        instr_valid = 1'b1;
        instr_op    = OP_SEQ;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("halt pc c%0d", c), 32'(pc), 32'(frozen));
            chk($sformatf("halt ready c%0d", c), 32'({instr_ready, fetch_en}), 32'd0);
        end
        do_reset();
        chk("recover ready", 32'(instr_ready), 32'd1);
        apply(mk(OP_SEQ, FL_Z, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0), "recover seq");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

- Consumer end of the flag-register condition interface. It sits in the control path between instruction decode and fetch.
- Each cycle it accepts one decoded flow-control instruction. It drives the 3-bit condition select to the flag register and samples the returned single-bit condition.
- It updates the program counter: sequential, jump, call, or return. It also maintains a small hardware return stack.

## Interface
Parameters:
- AW, 8, program-counter / target width
- DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset: one clock; reset is asynchronous and active-low
- instr_valid  in  1  decoded instruction present
- instr_ready  out  1  sequencer can accept; transfer when valid && ready at posedge
- instr_op  in  3  operation code (encoding under Operation)
- instr_cond  in  3  flag index: 0 Z, 1 NZ, 2 C, 3 NC, 4 P, 5 N, 6 PO, 7 PE
- instr_target  in  AW  jump/call destination
- oc_fl  out  3  condition select to flag register (registered)
- fl  in  1  selected flag returned by flag register (combinational from its flag state)
- pc  out  AW  current program counter
- fetch_en  out  1  fetch permitted this cycle
- branch_taken  out  1  one-cycle pulse: PC redirected by a control op
- stack_err  out  1  sticky: overflow or underflow occurred

## Operation
- Opcodes:
  - 0 NOP/SEQ
  - 1 JMP
  - 2 JC (jump if flag)
  - 3 CALL
  - 4 CC (call if flag)
  - 5 RET
  - 6 CR (return if flag)
  - 7 HALT
- States:
  - RUN:
    - instr_ready=1, fetch_en=1.
    - SEQ accepted → pc ← pc+1, stay RUN.
    - Ops 1–6 accepted → latch op/cond/target, oc_fl ← instr_cond, go EVAL.
    - HALT accepted → go HALTED.
  - EVAL:
    - instr_ready=0, fetch_en=0; oc_fl holds the latched cond.
    - Condition `take` = 1 for JMP/CALL/RET; `take` = fl sampled at the EVAL clock edge for JC/CC/CR.
    - At that edge, always go RUN.
  - HALTED: instr_ready=0, fetch_en=0; pc frozen. Exit only via reset.
- Resolution at the end of EVAL:
  - JMP/JC taken → pc ← target.
  - CALL/CC taken → push pc+1, then pc ← target.
  - RET/CR taken → pop, then pc ← popped value.
  - Not taken → pc ← pc+1.
  - branch_taken ← 1 for the following cycle only when pc ← target or popped value.
- Return stack:
  - DEPTH entries, pointer sp ranges 0..DEPTH.
  - Push when sp==DEPTH: no push, pc ← pc+1, stack_err ← 1, branch_taken stays 0.
  - Pop when sp==0: same treatment (pc+1, error, no redirect).
  - An untaken conditional never touches the stack or the error flag.
- Arithmetic: pc+1 wraps modulo 2^AW (all-ones → 0). The pushed value pc+1 wraps the same way.
- Reset values, forced immediately on rst_n low, including mid-EVAL:
  - state RUN, pc 0, oc_fl 0, sp 0, branch_taken 0, stack_err 0.
  - Stack contents are don't-care.
  - instr_ready and fetch_en follow state.

## Timing
- SEQ accepted at edge E → pc = old+1 after E. Throughput is 1 per cycle.
- Control op accepted at edge E:
  - Cycle E..E+1 is EVAL; oc_fl is valid from E.
  - fl is sampled at E+1, and pc updates at E+1.
  - branch_taken is high during cycle E+1..E+2.
  - Next accept is possible at E+2.
- Flag-update latency:
  - The flag register updates at the edge ending an ALU cycle.
  - A conditional op accepted at that same edge therefore sees the new flags during EVAL. No extra hazard stall is required.
- While instr_ready=0, the upstream stage holds instr_*; inputs are ignored.
- Releasing rst_n: the first acceptance is possible at the first rising edge after deassertion.

## Structure
- Shared package `branch_pkg`:
  - opcode localparams (OP_SEQ..OP_HALT)
  - state encoding (ST_RUN, ST_EVAL, ST_HALTED)
  - flag index constants (FL_Z..FL_PE), used by the flag register and decoder as well
- Sub-module `return_stack`:
  - parameterised by AW and DEPTH
  - ports: push, pop, din, dout, full, empty
  - async active-low reset clears the pointer only
- Top level holds the FSM, pc register, oc_fl register, and error/pulse flops.

## Test plan
- Reset then 5 SEQ back-to-back → pc reads 0,1,2,3,4,5 on consecutive cycles; oc_fl=0; branch_taken never high.
- JC cond=2 (C), target 0x40, fl=1 during EVAL → pc=0x40 two cycles after accept, branch_taken 1-cycle pulse. Repeat with fl=0 → pc=old+1, no pulse.
- CALL 0x10 from pc=0x05, then RET → pc 0x10 then 0x06. Nest DEPTH+1 CALLs → last is not taken, pc+1, stack_err=1 sticky.
- RET on empty stack at pc=0xFF → pc=0x00 (wrap), stack_err=1, no branch_taken. CR on empty with fl=0 → no error.
- rst_n pulled low mid-EVAL of a CALL → pc=0, sp=0, state RUN immediately. After release, RET underflows (stack confirmed cleared).
- HALT accepted → instr_ready/fetch_en low, pc frozen for 20 cycles despite instr_valid=1. Only reset recovers.
